m2_digest_out: RTL

Finalisation stage on the output side of the m2 SHA-256 round engine. On a `fin_start` pulse it captures the eight working registers a..h after round 64 together with the chaining value. It forms the digest H[i] = state[i] + iv[i] mod 2^32, one word per enabled cycle, and evaluates the share-hit condition on H7. It then streams the eight digest words to the result/compare logic over a valid/ready handshake. It consumes what the working-register block produces and frees that block to reload the initial state as soon as capture is done.

---
 rtl/m2_digest_out_if.sv | 28 ++
 rtl/m2_digest_out.sv | 114 +++++++++++
 2 files changed

// File: rtl/m2_digest_out_if.sv
// Digest word stream from the m2 finalisation stage to the result/compare logic.
// The master presents words and the slave accepts them with dout_ready.
interface m2_digest_out_if;
    logic [31:0] dout;
    logic [2:0]  dout_idx;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        hit;

    modport master (
        output dout,
        output dout_idx,
        output dout_valid,
        output dout_last,
        output hit,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_idx,
        input  dout_valid,
        input  dout_last,
        input  hit,
        output dout_ready
    );
endinterface

// File: rtl/m2_digest_out.sv
// SHA-256 finalisation: captures post-round-64 state and chaining value, adds them
// word by word through one shared 32-bit adder, then streams the eight digest words.
module m2_digest_out #(
    parameter int unsigned ZERO_BITS = 32
) (
    input  logic           clk_h,
    input  logic           rst_h,
    input  logic           clk_h_en,
    input  logic           fin_start,
    input  logic [31:0]    a,
    input  logic [31:0]    b,
    input  logic [31:0]    c,
    input  logic [31:0]    d,
    input  logic [31:0]    e,
    input  logic [31:0]    f,
    input  logic [31:0]    g,
    input  logic [31:0]    h,
    input  logic [255:0]   iv_in,
    m2_digest_out_if.master dout_bus,
    output logic           busy,
    output logic           overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    // Bits of H7 that must all be zero for a share hit.
    localparam logic [31:0] HIT_MASK = 32'hFFFF_FFFF << (32 - ZERO_BITS);

    logic [1:0]  state;
    logic [2:0]  k;
    logic [2:0]  j;
    logic [31:0] st  [8];
    logic [31:0] ivr [8];
    logic [31:0] dig [8];
    logic [31:0] cap [8];
    logic [31:0] sum;
    logic        hit_q;
    logic        ovr_q;
    logic        send;

    always_comb begin
        cap[0] = a;
        cap[1] = b;
        cap[2] = c;
        cap[3] = d;
        cap[4] = e;
        cap[5] = f;
        cap[6] = g;
        cap[7] = h;
    end

    assign sum  = st[k] + ivr[k];
    assign send = (state == S_SEND);

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state <= S_IDLE;
            k     <= '0;
            j     <= '0;
            hit_q <= 1'b0;
            ovr_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                st[i]  <= '0;
                ivr[i] <= '0;
                dig[i] <= '0;
            end
        end else if (clk_h_en) begin
            // A start request outside IDLE is dropped and flagged, never queued.
            ovr_q <= fin_start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (fin_start) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            st[i]  <= cap[i];
                            ivr[i] <= iv_in[32*i +: 32];
                        end
                        k     <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    dig[k] <= sum;
                    k      <= k + 3'd1;
                    if (k == 3'd7) begin
                        hit_q <= ((sum & HIT_MASK) == 32'd0);
                        j     <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (dout_bus.dout_ready) begin
                        j <= j + 3'd1;
                        if (j == 3'd7) begin
                            hit_q <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dout_bus.dout_valid = send;
    assign dout_bus.dout       = send ? dig[j] : '0;
    assign dout_bus.dout_idx   = j;
    assign dout_bus.dout_last  = send && (j == 3'd7);
    assign dout_bus.hit        = hit_q;
    assign busy                = (state != S_IDLE);
    assign overrun             = ovr_q;

endmodule
